// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial front end: shifts a pair of W-bit operands out in lockstep,
// one bit per clock, with word framing flags and a one-entry pending buffer.
module serial_pair_serializer #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   output logic         out_a,
   output logic         out_b,
   output logic         out_first,
   output logic         out_last
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic [W-1:0]    pend_a_q, pend_a_d, pend_b_q, pend_b_d;
   logic            pend_valid_q, pend_valid_d;

   logic            accept;
   logic            lastBit;
   logic [W-1:0]    shiftA, shiftB;

   // Handshake and word-boundary decode, plus the next value of the shifters
   always_comb begin
      accept  = in_valid && !pend_valid_q;
      lastBit = (state_q == SHIFT) && (cnt_q == CW'(W - 1));
      if (MSB_FIRST) begin
         shiftA = sh_a_q << 1;
         shiftB = sh_b_q << 1;
      end else begin
         shiftA = sh_a_q >> 1;
         shiftB = sh_b_q >> 1;
      end
   end

   // Next-state logic; flush overrides everything, pending pair beats bypass at end of word
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sh_a_d       = sh_a_q;
      sh_b_d       = sh_b_q;
      pend_a_d     = pend_a_q;
      pend_b_d     = pend_b_q;
      pend_valid_d = pend_valid_q;
      if (flush) begin
         state_d      = IDLE;
         pend_valid_d = 1'b0;
         cnt_d        = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  sh_a_d  = in_a;
                  sh_b_d  = in_b;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (lastBit) begin
                  cnt_d = '0;
                  if (pend_valid_q) begin
                     sh_a_d       = pend_a_q;
                     sh_b_d       = pend_b_q;
                     pend_valid_d = 1'b0;
                  end else if (accept) begin
                     sh_a_d = in_a;
                     sh_b_d = in_b;
                  end else begin
                     sh_a_d  = shiftA;
                     sh_b_d  = shiftB;
                     state_d = IDLE;
                  end
               end else begin
                  sh_a_d = shiftA;
                  sh_b_d = shiftB;
                  cnt_d  = cnt_q + CW'(1);
                  if (accept) begin
                     pend_a_d     = in_a;
                     pend_b_d     = in_b;
                     pend_valid_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sh_a_q       <= '0;
         sh_b_q       <= '0;
         pend_a_q     <= '0;
         pend_b_q     <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_a_q       <= sh_a_d;
         sh_b_q       <= sh_b_d;
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // Outputs are decoded from registers only
   assign in_ready  = !pend_valid_q;
   assign out_valid = (state_q == SHIFT);
   assign out_a     = MSB_FIRST ? sh_a_q[W-1] : sh_a_q[0];
   assign out_b     = MSB_FIRST ? sh_b_q[W-1] : sh_b_q[0];
   assign out_first = (state_q == SHIFT) && (cnt_q == '0);
   assign out_last  = lastBit;

endmodule

// File: doc/serial_pair_serializer.md
# serial_pair_serializer

Parallel-to-serial front end for the bit-serial comparison path. It accepts a pair of W-bit operands through a valid/ready handshake and shifts both operands out one bit per clock, in lockstep. The default order is most significant bit first. Word-framing flags (out_first, out_last) let downstream bit-serial comparators restart their running state at each word boundary. A one-entry pending buffer lets consecutive words stream with no idle cycle between them.

## Interface
- W, default 8: operand width in bits, W >= 1.
- MSB_FIRST, default 1: 1 shifts bit W-1 first; 0 shifts bit 0 first.

- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous drop of the current word and the pending word.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept a pair. Equals !pend_valid.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  out_a and out_b carry a valid bit this cycle.
- out_a  out  1  current serial bit of A.
- out_b  out  1  current serial bit of B.
- out_first  out  1  first bit of a word.
- out_last  out  1  last bit of a word.

## Operation
- Storage: shift registers sh_a/sh_b (W bits each), bit counter cnt (width max(1,$clog2(W))), pending registers pend_a/pend_b with pend_valid.
- States:
  - IDLE: out_valid=0.
  - SHIFT: out_valid=1.
- All outputs are registered or are decoded from registers only. No combinational path runs from any input to any output.
- Bit select:
  - out_a = sh_a[W-1] when MSB_FIRST=1, else sh_a[0]. Same rule for out_b.
  - The shift direction matches the bit select.
- Flags:
  - out_first = SHIFT && cnt==0.
  - out_last = SHIFT && cnt==W-1.
  - For W=1 both flags are high on every valid bit.
- Handshake: a pair is accepted on any edge where in_valid && in_ready. After acceptance the source may change in_a/in_b immediately.
- Accept in IDLE: load sh_a/sh_b, set cnt=0, go to SHIFT.
- Accept in SHIFT when the current cycle is not the last bit: store the pair in pend_*, set pend_valid=1. in_ready goes low next cycle.
- End of word (edge ending an out_last cycle), highest priority first:
  1. pend_valid=1: move pend_* into sh_*, set cnt=0, clear pend_valid.
  2. Else, a handshake on this same edge: load the incoming pair directly into sh_*, bypassing pend_*.
  3. Else: go to IDLE.
  - Cases 1 and 2 stay in SHIFT with no gap cycle.
- Simultaneous events in the last-bit cycle with pend_valid=1: in_ready is 0, so there is no conflict.
- flush=1 at an edge:
  - state becomes IDLE, pend_valid becomes 0, cnt becomes 0.
  - Any handshake in the same cycle is ignored, and the pair is dropped.
  - flush overrides every other transition.
- Reset (rst=0, any time including mid-word):
  - state IDLE, cnt=0, pend_valid=0, sh_*=0, pend_*=0.
  - Outputs: out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0, in_ready=1.
  - A partially shifted word is lost.

## Timing
- Latency: a pair accepted at edge k, with the block idle, shows its first bit in cycle k+1 and its last bit in cycle k+W.
- Throughput: one pair every W cycles, sustained. out_valid stays continuously high while words arrive on time.
- in_ready drops for at most W-1 cycles per word. It rises again in the cycle after the pending pair moves into sh_*.
- flush or rst deassertion: the first new word can be accepted on the next edge.

## Test plan
- W=4, MSB_FIRST=1, single pair a=0110, b=0101 accepted from IDLE:
  - out_a = 0,1,1,0 and out_b = 0,1,0,1 over cycles k+1..k+4.
  - out_first high at k+1 only; out_last high at k+4 only.
  - out_valid drops at k+5.
- Back-to-back: second pair (a=1000, b=0111) offered during the first word:
  - in_ready goes low until the pending pair is loaded.
  - out_valid stays high for 8 consecutive cycles; out_first is high in cycles 1 and 5.
- Bypass: pair offered exactly in the out_last cycle with pend_valid=0:
  - accepted directly; the next cycle shows its first bit, with no gap.
- MSB_FIRST=0, a=0110, b=0101 → out_a = 0,1,1,0 and out_b = 1,0,1,0.
- flush on the 2nd bit with a pending pair present:
  - next cycle out_valid=0 and in_ready=1.
  - A new pair then starts cleanly with out_first=1.
- rst asserted asynchronously mid-word and mid-cycle:
  - all outputs go to their reset values immediately, and in_ready=1.
  - Same check with W=1: out_first=out_last=1 on every bit.
